// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// One byte in flight at a time; tracks tx_busy until the frame has left the line.
module uart_tx_arbiter #(
  parameter int N_REQ         = 2,
  parameter int START_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [8*N_REQ-1:0]       req_data,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     send_data,
  output logic [7:0]               data2send,
  input  logic                     tx_busy,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     err_start,
  output logic [1:0]               state_dbg
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  // Handshake: a requester holds req_valid and its byte until it sees its
  // req_ready bit pulse for one cycle; only the IDLE state samples req_valid.
  state_t           state, state_d;
  logic [CW-1:0]    cnt, cnt_d;
  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic [IDW-1:0]   cand;
  logic [7:0]       pick_data;
  logic [N_REQ-1:0] ready_d;
  logic             send_d, err_d, load_d;
  logic             timeout;

  assign timeout   = (cnt == CNT_LAST);
  assign state_dbg = state;

  // Scan starts one past the last grant, so the previous winner ranks last.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand = IDW'((int'(grant_id) + off) % N_REQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_idx == IDW'(i)) pick_data = req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:      if (pick_found) state_d = S_ISSUE;
      S_ISSUE:     state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        // A tx_busy rise on the timeout edge still counts as a start.
        if (tx_busy)      state_d = S_WAIT_DONE;
        else if (timeout) state_d = S_IDLE;
      end
      S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_d = '0;
    send_d  = 1'b0;
    err_d   = 1'b0;
    load_d  = 1'b0;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        if (pick_found) begin
          load_d  = 1'b1;
          send_d  = 1'b1;
          ready_d = N_REQ'(1) << pick_idx;
        end
      end
      S_ISSUE: cnt_d = '0;
      S_WAIT_BUSY: begin
        if (!tx_busy) begin
          if (timeout) err_d = 1'b1;
          else         cnt_d = cnt + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready <= '0;
      send_data <= 1'b0;
      data2send <= '0;
      grant_id  <= IDW'(N_REQ - 1);
      busy      <= 1'b0;
      err_start <= 1'b0;
      cnt       <= '0;
    end else begin
      req_ready <= ready_d;
      send_data <= send_d;
      err_start <= err_d;
      busy      <= (state_d != S_IDLE);
      cnt       <= cnt_d;
      if (load_d) begin
        data2send <= pick_data;
        grant_id  <= pick_idx;
      end
    end
  end

endmodule
